// File: rtl/tmds_encoder_8b10b.sv
// DVI TMDS 8b/10b encoder for one colour channel, three-register pipeline.
// Optional monitor ports (disparity, disp_err) are enabled by TMDS_ENC_DISPARITY_MON_EN.
module tmds_encoder_8b10b #(
    parameter int PIPE_STAGES = 3
) (
    input  logic              paralell_clk,
    input  logic              reset,
    input  logic              de,
    input  logic [7:0]        din,
    input  logic              c0,
    input  logic              c1,
`ifdef TMDS_ENC_DISPARITY_MON_EN
    output logic signed [4:0] disparity,
    output logic              disp_err,
`endif
    output logic [9:0]        dout
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    if (PIPE_STAGES != 3) begin : g_bad_pipe_stages
        $error("tmds_encoder_8b10b: PIPE_STAGES must be 3");
    end

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, v[i]};
        end
        return sum;
    endfunction

    function automatic logic [8:0] build_qm(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic       s1_de_q;
    logic [1:0] s1_c_q;
    logic [7:0] s1_din_q;
    logic [3:0] s1_n1_q;

    logic       use_xnor_s;
    logic [8:0] qm_d;
    logic [3:0] qm_n1_s;

    logic       s2_de_q;
    logic [1:0] s2_c_q;
    logic [8:0] s2_qm_q;
    logic [3:0] s2_n1_q;
    logic [3:0] s2_n0_q;

    logic [4:0] n1_s;
    logic [4:0] n0_s;
    logic [4:0] delta_s;
    logic [4:0] cnt_d;
    logic [9:0] dout_d;
    logic [4:0] cnt_q;
    logic [9:0] dout_q;

    // Stage 1: capture inputs and the data popcount
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            s1_de_q  <= 1'b0;
            s1_c_q   <= 2'b00;
            s1_din_q <= 8'd0;
            s1_n1_q  <= 4'd0;
        end else begin
            s1_de_q  <= de;
            s1_c_q   <= {c1, c0};
            s1_din_q <= din;
            s1_n1_q  <= popcount8(din);
        end
    end

    // Stage 2 combinational: transition-minimising XOR/XNOR chain
    always_comb begin
        use_xnor_s = 1'b0;
        if ((s1_n1_q > 4'd4) || ((s1_n1_q == 4'd4) && !s1_din_q[0])) begin
            use_xnor_s = 1'b1;
        end else begin
            use_xnor_s = 1'b0;
        end
        qm_d    = build_qm(s1_din_q, use_xnor_s);
        qm_n1_s = popcount8(qm_d[7:0]);
    end

    // Stage 2 registers
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            s2_de_q <= 1'b0;
            s2_c_q  <= 2'b00;
            s2_qm_q <= 9'd0;
            s2_n1_q <= 4'd0;
            s2_n0_q <= 4'd0;
        end else begin
            s2_de_q <= s1_de_q;
            s2_c_q  <= s1_c_q;
            s2_qm_q <= qm_d;
            s2_n1_q <= qm_n1_s;
            s2_n0_q <= 4'd8 - qm_n1_s;
        end
    end

    // Stage 3 combinational: DC-balance inversion choice and disparity step
    always_comb begin
        n1_s    = {1'b0, s2_n1_q};
        n0_s    = {1'b0, s2_n0_q};
        dout_d  = TOK_00;
        delta_s = 5'd0;
        cnt_d   = 5'd0;
        if (!s2_de_q) begin
            case (s2_c_q)
                2'b00:   dout_d = TOK_00;
                2'b01:   dout_d = TOK_01;
                2'b10:   dout_d = TOK_10;
                2'b11:   dout_d = TOK_11;
                default: dout_d = TOK_00;
            endcase
            delta_s = 5'd0;
            cnt_d   = 5'd0;
        end else if ((cnt_q == 5'd0) || (s2_n1_q == s2_n0_q)) begin
            dout_d  = {~s2_qm_q[8], s2_qm_q[8], s2_qm_q[8] ? s2_qm_q[7:0] : ~s2_qm_q[7:0]};
            delta_s = s2_qm_q[8] ? (n1_s - n0_s) : (n0_s - n1_s);
            cnt_d   = cnt_q + delta_s;
        end else if ((!cnt_q[4] && (s2_n1_q > s2_n0_q)) || (cnt_q[4] && (s2_n0_q > s2_n1_q))) begin
            dout_d  = {1'b1, s2_qm_q[8], ~s2_qm_q[7:0]};
            delta_s = {3'd0, s2_qm_q[8], 1'b0} + n0_s - n1_s;
            cnt_d   = cnt_q + delta_s;
        end else begin
            dout_d  = {1'b0, s2_qm_q[8], s2_qm_q[7:0]};
            delta_s = n1_s - n0_s - {3'd0, ~s2_qm_q[8], 1'b0};
            cnt_d   = cnt_q + delta_s;
        end
    end

    // Stage 3 registers: output symbol and running disparity
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            dout_q <= TOK_00;
            cnt_q  <= 5'd0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

`ifdef TMDS_ENC_DISPARITY_MON_EN
    logic [5:0] cnt_wide_s;
    logic       cnt_oor_s;
    logic       err_q;

    // Widened sum exposes the excursions that the 5-bit counter would wrap
    always_comb begin
        cnt_wide_s = {cnt_q[4], cnt_q} + {delta_s[4], delta_s};
        cnt_oor_s  = 1'b0;
        if (($signed(cnt_wide_s) > 6'sd10) || ($signed(cnt_wide_s) < -6'sd10)) begin
            cnt_oor_s = 1'b1;
        end else begin
            cnt_oor_s = 1'b0;
        end
    end

    // Sticky disparity-range error flag
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (s2_de_q && cnt_oor_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign disparity = $signed(cnt_q);
    assign disp_err  = err_q;
`endif

endmodule
